// File: rtl/apb_fabric_req_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package     : proj_param_pkg / apb_fabric_pkg
// Description : Project-wide APB widths and the shared types of the APB
//               request bridge (FSM state encoding, response bundle).
// Revision    : 1.0 - initial release
// ============================================================================

package proj_param_pkg;
  localparam int unsigned PROJ_PADDR = 32;
  localparam int unsigned PROJ_PDATA = 32;
endpackage : proj_param_pkg

package apb_fabric_pkg;

  // Bridge sequencer states; one full APB transfer walks all four in order.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_br_state_e;

  // Byte-strobe width for the project data bus.
  localparam int unsigned PSTRB = proj_param_pkg::PROJ_PDATA / 8;

  // Response bundle at project data width.
  typedef struct packed {
    logic [proj_param_pkg::PROJ_PDATA-1:0] rdata;
    logic                                  err;
    logic                                  timeout;
  } apb_br_rsp_t;

endpackage : apb_fabric_pkg
`default_nettype wire

// File: rtl/apb_fabric_req_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_fabric_req_bridge
// Description : Converts a valid/ready request into one APB3/APB4 master
//               transfer (SETUP -> ACCESS) and returns the result on a
//               valid/ready response channel. Slave wait states are bounded
//               by a timeout. Exactly one transfer outstanding.
// Ports       : pclk/presetn        clock, async active-low reset
//               req_*               request channel (valid/ready)
//               rsp_*               response channel (valid/ready)
//               psel..pstrb         APB master outputs
//               pready/prdata/pslverr APB slave inputs
// Revision    : 1.0 - initial release
// ============================================================================

module apb_fabric_req_bridge
  import apb_fabric_pkg::*;
#(
  parameter int unsigned PADDR   = proj_param_pkg::PROJ_PADDR,
  parameter int unsigned PDATA   = proj_param_pkg::PROJ_PDATA,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  // request channel
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [PADDR-1:0]   req_addr,
  input  logic [PDATA-1:0]   req_wdata,
  input  logic [PDATA/8-1:0] req_strb,
  // response channel
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [PDATA-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  // APB master
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [PADDR-1:0]   paddr,
  output logic [PDATA-1:0]   pwdata,
  output logic [PDATA/8-1:0] pstrb,
  input  logic               pready,
  input  logic [PDATA-1:0]   prdata,
  input  logic               pslverr
);

  localparam int unsigned STRB_W    = PDATA / 8;
  localparam int unsigned CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_MAX_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_I);

  apb_br_state_e     state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [PADDR-1:0]  paddr_q, paddr_d;
  logic [PDATA-1:0]  pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [PDATA-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic req_hs;
  logic timeout_hit;

  assign req_hs = (state_q == IDLE) && req_valid;

  // A pready coinciding with the limit cycle takes priority, so the abort
  // condition is qualified with !pready.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_MAX) && !pready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)             state_d = SETUP;
      SETUP:                              state_d = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready)             state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode; combinational from state so a reset drops psel at once.
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      SETUP:   psel      = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      RESP:    rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: request capture, response capture, wait-state counter
  // --------------------------------------------------------------------------
  always_comb begin
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    if (req_hs) begin
      pwrite_d = req_write;
      paddr_d  = req_addr;
      pwdata_d = req_wdata;
      pstrb_d  = req_write ? req_strb : '0;
      cnt_d    = '0;
    end

    if (state_q == ACCESS) begin
      if (pready) begin
        rsp_rdata_d   = pwrite_q ? '0 : prdata;
        rsp_err_d     = pslverr;
        rsp_timeout_d = 1'b0;
      end else if (timeout_hit) begin
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b1;
      end else if ((TIMEOUT != 0) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if ((state_q == RESP) && rsp_ready) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule : apb_fabric_req_bridge
`default_nettype wire

// File: tb/tb_apb_fabric_req_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_fabric_req_bridge
// Description : Self-checking bench for apb_fabric_req_bridge. Directed
//               scenarios followed by randomized transfers; expected values
//               come from a transaction-level model of the bridge rules.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_apb_fabric_req_bridge;

  localparam int unsigned PADDR   = 32;
  localparam int unsigned PDATA   = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              pclk    = 1'b0;
  logic              presetn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [PADDR-1:0]  req_addr  = '0;
  logic [PDATA-1:0]  req_wdata = '0;
  logic [PDATA/8-1:0] req_strb = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [PDATA-1:0]  rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel, penable, pwrite;
  logic [PADDR-1:0]  paddr;
  logic [PDATA-1:0]  pwdata;
  logic [PDATA/8-1:0] pstrb;
  logic              pready  = 1'b0;
  logic [PDATA-1:0]  prdata  = '0;
  logic              pslverr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  apb_fabric_req_bridge #(
    .PADDR   (PADDR),
    .PDATA   (PDATA),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drive random values onto slave inputs that the bridge must ignore.
  task automatic slave_noise();
    pready  = 1'($urandom_range(0, 1));
    pslverr = 1'($urandom_range(0, 1));
    prdata  = $urandom;
  endtask

  // One complete transfer, entered and left at a negedge with the bridge IDLE.
  // waits = number of ACCESS cycles with pready low before pready is given.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int waits, input bit slverr,
                        input logic [31:0] rdata, input int rsp_delay);
    bit          exp_to;
    int          exp_acc;
    logic [31:0] exp_rdata;
    bit          exp_err;
    logic [3:0]  exp_strb;
    int          n_acc;

    // Transaction-level model of the outcome.
    exp_to    = (TIMEOUT != 0) && (waits >= int'(TIMEOUT));
    exp_acc   = exp_to ? int'(TIMEOUT) : waits + 1;
    exp_rdata = (wr || exp_to) ? 32'h0 : rdata;
    exp_err   = exp_to ? 1'b1 : slverr;
    exp_strb  = wr ? strb : 4'h0;

    // Cycle N: request presented while IDLE.
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = wr ? strb : 4'($urandom);
    slave_noise();
    check("req_ready_idle", 64'(req_ready), 64'd1);
    check("rsp_valid_idle", 64'(rsp_valid), 64'd0);

    // Cycle N+1: SETUP; request inputs now scrambled and must not matter.
    @(negedge pclk);
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_strb  = 4'($urandom);
    slave_noise();
    check("setup_psel",    64'(psel),    64'd1);
    check("setup_penable", 64'(penable), 64'd0);
    check("setup_pwrite",  64'(pwrite),  64'(wr));
    check("setup_paddr",   64'(paddr),   64'(addr));
    check("setup_pwdata",  64'(pwdata),  64'(wdata));
    check("setup_pstrb",   64'(pstrb),   64'(exp_strb));
    check("setup_req_ready", 64'(req_ready), 64'd0);

    // Cycle N+2 onward: ACCESS, acting as the slave.
    @(negedge pclk);
    req_valid = 1'b0;
    n_acc = 0;
    while (psel && penable && n_acc < 40) begin
      n_acc++;
      pready  = (n_acc == waits + 1);
      prdata  = pready ? rdata : $urandom;
      pslverr = pready ? slverr : 1'($urandom_range(0, 1));
      @(negedge pclk);
    end
    slave_noise();
    check("access_cycles", 64'(n_acc), 64'(exp_acc));
    check("resp_valid",    64'(rsp_valid),   64'd1);
    check("resp_psel",     64'(psel),        64'd0);
    check("resp_penable",  64'(penable),     64'd0);
    check("resp_rdata",    64'(rsp_rdata),   64'(exp_rdata));
    check("resp_err",      64'(rsp_err),     64'(exp_err));
    check("resp_timeout",  64'(rsp_timeout), 64'(exp_to));
    check("hold_paddr",    64'(paddr),       64'(addr));

    // Back-pressure: requester keeps asking, response must stay put.
    for (int d = 0; d < rsp_delay; d++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = $urandom;
      slave_noise();
      @(negedge pclk);
      check("bp_rsp_valid", 64'(rsp_valid),   64'd1);
      check("bp_req_ready", 64'(req_ready),   64'd0);
      check("bp_rdata",     64'(rsp_rdata),   64'(exp_rdata));
      check("bp_err",       64'(rsp_err),     64'(exp_err));
      check("bp_timeout",   64'(rsp_timeout), 64'(exp_to));
    end

    // Consume: req_valid stays high in this cycle and must not be taken.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    slave_noise();
    check("consume_req_ready", 64'(req_ready), 64'd0);
    @(negedge pclk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    check("idle_req_ready", 64'(req_ready), 64'd1);
    check("idle_psel",      64'(psel),      64'd0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge pclk);
    check("rst_psel",        64'(psel),        64'd0);
    check("rst_penable",     64'(penable),     64'd0);
    check("rst_pwrite",      64'(pwrite),      64'd0);
    check("rst_paddr",       64'(paddr),       64'd0);
    check("rst_pwdata",      64'(pwdata),      64'd0);
    check("rst_pstrb",       64'(pstrb),       64'd0);
    check("rst_rsp_valid",   64'(rsp_valid),   64'd0);
    check("rst_rsp_rdata",   64'(rsp_rdata),   64'd0);
    check("rst_rsp_err",     64'(rsp_err),     64'd0);
    check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    check("rst_req_ready",   64'(req_ready),   64'd1);
    presetn = 1'b1;
    @(negedge pclk);

    // Zero-wait read.
    do_txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, 1'b0, 32'hDEAD_BEEF, 0);
    // Write with three wait states (penable high four cycles).
    do_txn(1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 3, 1'b0, 32'h5555_AAAA, 2);
    // Read completing with slave error.
    do_txn(1'b0, 32'h0000_0080, 32'h0, 4'h0, 2, 1'b1, 32'hCAFE_F00D, 1);
    // pready never arrives in time: timeout abort.
    do_txn(1'b0, 32'h0000_2000, 32'h0, 4'h0, 30, 1'b0, 32'h1111_2222, 0);
    // pready on the limit cycle wins over the timeout.
    do_txn(1'b0, 32'h0000_2004, 32'h0, 4'h0, 15, 1'b0, 32'h3333_4444, 0);
    // First cycle past the limit: abort on a write.
    do_txn(1'b1, 32'h0000_2008, 32'hABCD_0123, 4'h5, 16, 1'b0, 32'h0, 0);
    // Long response back-pressure.
    do_txn(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D, 10);

    // Reset in the middle of ACCESS.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_4000;
    req_wdata = 32'h7777_8888;
    req_strb  = 4'h3;
    pready    = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    pready = 1'b0;
    check("mid_access_penable", 64'(penable), 64'd1);
    #2 presetn = 1'b0;
    #1;
    check("mid_rst_psel",      64'(psel),      64'd0);
    check("mid_rst_penable",   64'(penable),   64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slave_noise();
      @(negedge pclk);
      check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("post_rst_psel",      64'(psel),      64'd0);
    end
    pready = 1'b0;
    do_txn(1'b0, 32'h0000_4004, 32'h0, 4'h0, 0, 1'b0, 32'h600D_CAFE, 0);

    // Randomized transfers.
    for (int t = 0; t < 60; t++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_apb_fabric_req_bridge
`default_nettype wire
